// File: rtl/rst_release_seq.sv
// rtl/rst_release_seq.sv - reset synchroniser, stretcher and ordered per-domain reset release
// Optional watchdog re-entry compiled in with RST_SEQ_WDOG_EN.
module rst_release_seq #(
  parameter int NUM_DOM        = 3,
  parameter int STRETCH_CYCLES = 16,
  parameter int GAP_CYCLES     = 4,
  parameter int WDOG_CYCLES    = 1024
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               sw_rst_req_i,
  input  logic               alive_i,
  output logic [NUM_DOM-1:0] rst_dom_no,
  output logic               rst_done_o,
  output logic [1:0]         rst_cause_o
);

  localparam int MAX_SG = (STRETCH_CYCLES > GAP_CYCLES) ? STRETCH_CYCLES : GAP_CYCLES;
  localparam int MAX_C  = (MAX_SG > WDOG_CYCLES) ? MAX_SG : WDOG_CYCLES;
  localparam int CNT_W  = $clog2(MAX_C + 1);
  localparam int IDX_W  = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] DOM_LAST     = IDX_W'(NUM_DOM - 1);

  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_SW   = 2'd1;
`ifdef RST_SEQ_WDOG_EN
  localparam logic [1:0] CAUSE_WDOG = 2'd2;
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);
`else
  logic unused_alive;
  assign unused_alive = alive_i;
`endif

  typedef enum logic [1:0] {HOLD, STRETCH, RELEASE, ACTIVE} state_t;

  state_t            state;
  logic [1:0]        sync_q;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  dom_idx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= HOLD;
      cnt         <= '0;
      dom_idx     <= '0;
      rst_dom_no  <= '0;
      rst_done_o  <= 1'b0;
      rst_cause_o <= CAUSE_POR;
    end else begin
      case (state)
        HOLD: begin
          // sync_q[0] high means the synchronised reset rises on this very edge
          if (sync_q[0]) begin
            state <= STRETCH;
            cnt   <= '0;
          end
        end
        STRETCH: begin
          if (cnt == STRETCH_LAST) begin
            cnt           <= '0;
            rst_dom_no[0] <= 1'b1;
            if (NUM_DOM == 1) begin
              rst_done_o <= 1'b1;
              state      <= ACTIVE;
            end else begin
              dom_idx <= IDX_W'(1);
              state   <= RELEASE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt == GAP_LAST) begin
            cnt                 <= '0;
            rst_dom_no[dom_idx] <= 1'b1;
            if (dom_idx == DOM_LAST) begin
              rst_done_o <= 1'b1;
              state      <= ACTIVE;
            end else begin
              dom_idx <= dom_idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ACTIVE: begin
          if (sw_rst_req_i) begin
            rst_dom_no  <= '0;
            rst_done_o  <= 1'b0;
            rst_cause_o <= CAUSE_SW;
            dom_idx     <= '0;
            cnt         <= '0;
            state       <= STRETCH;
          end
`ifdef RST_SEQ_WDOG_EN
          // cnt doubles as the watchdog counter; it is already zero on ACTIVE entry
          else if (alive_i) begin
            cnt <= '0;
          end else if (cnt == WDOG_LAST) begin
            rst_dom_no  <= '0;
            rst_done_o  <= 1'b0;
            rst_cause_o <= CAUSE_WDOG;
            dom_idx     <= '0;
            cnt         <= '0;
            state       <= STRETCH;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_rst_release_seq.sv
// tb/tb_rst_release_seq.sv - directed and random checks of rst_release_seq against an edge-number model
// Watchdog scenarios run only when RST_SEQ_WDOG_EN is defined.
module tb_rst_release_seq;

  localparam int ND = 3;
  localparam int ST = 16;
  localparam int GP = 4;
  localparam int WD = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          sw = 1'b0;
  logic          alive = 1'b0;
  logic [ND-1:0] dom;
  logic          done;
  logic [1:0]    cause;
  logic [0:0]    dom1;
  logic          done1;
  logic [1:0]    cause1;

  int n_checks = 0;
  int n_fail = 0;

  // model: edges since reset release, edge the current stretch started, cause, last kick edge
  int n = 0;
  int start = 2;
  int mcause = 0;
  int last_kick = 0;

  rst_release_seq #(.NUM_DOM(ND), .STRETCH_CYCLES(ST), .GAP_CYCLES(GP), .WDOG_CYCLES(WD)) dut (
    .clk_i(clk), .rst_ni(rst_n), .sw_rst_req_i(sw), .alive_i(alive),
    .rst_dom_no(dom), .rst_done_o(done), .rst_cause_o(cause)
  );

  rst_release_seq #(.NUM_DOM(1), .STRETCH_CYCLES(ST), .GAP_CYCLES(GP), .WDOG_CYCLES(WD)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .sw_rst_req_i(sw), .alive_i(alive),
    .rst_dom_no(dom1), .rst_done_o(done1), .rst_cause_o(cause1)
  );

  always #5 clk = ~clk;

  function automatic int done_edge();
    return start + ST + (ND - 1) * GP;
  endfunction

  function automatic logic [ND-1:0] exp_dom();
    logic [ND-1:0] r;
    for (int k = 0; k < ND; k++) r[k] = (n >= start + ST + k * GP);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("dom", 32'(dom), 32'(exp_dom()));
    chk("done", 32'(done), 32'(n >= done_edge()));
    chk("cause", 32'(cause), 32'(mcause));
  endtask

  task automatic model_edge();
    int de;
    int ref_e;
    if (!rst_n) return;
    n++;
    de = done_edge();
    if (n > de) begin
      ref_e = (last_kick > de) ? last_kick : de;
      if (sw) begin
        start = n; mcause = 1; last_kick = 0;
      end
`ifdef RST_SEQ_WDOG_EN
      else if (alive) begin
        last_kick = n;
      end else if (n - ref_e == WD) begin
        start = n; mcause = 2; last_kick = 0;
      end
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    n = 0; start = 2; mcause = 0; last_kick = 0;
    #1;
    chk("rst_dom", 32'(dom), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cause", 32'(cause), 32'd0);
  endtask

  task automatic run_to(input int target);
    while (n < target) step();
  endtask

  initial begin
    int e;
    #1;
    do_reset();
    repeat (5) step();
    rst_n = 1'b1;

    // POR with default timing
    while (n < 30) begin
      step();
      if (n == 17) begin
        chk("por_dom_e17", 32'(dom), 32'd0);
        chk("single_dom_e17", 32'(dom1), 32'd0);
      end
      if (n == 18) begin
        chk("por_dom_e18", 32'(dom), 32'b001);
        chk("single_dom_e18", 32'(dom1), 32'd1);
        chk("single_done_e18", 32'(done1), 32'd1);
        chk("single_cause_e18", 32'(cause1), 32'd0);
      end
      if (n == 22) chk("por_dom_e22", 32'(dom), 32'b011);
      if (n == 26) begin
        chk("por_dom_e26", 32'(dom), 32'b111);
        chk("por_done_e26", 32'(done), 32'd1);
      end
    end

    // software reset in ACTIVE
    sw = 1'b1;
    step();
    sw = 1'b0;
    e = n;
    chk("sw_dom", 32'(dom), 32'd0);
    chk("sw_cause", 32'(cause), 32'd1);
    run_to(e + 16);
    chk("sw_dom0", 32'(dom), 32'b001);
    run_to(e + 24);
    chk("sw_done", 32'(done), 32'd1);
`ifdef RST_SEQ_WDOG_EN
    run_to(e + 32);
    chk("wdog_cause", 32'(cause), 32'd2);
    chk("wdog_dom", 32'(dom), 32'd0);
`endif

    // request during RELEASE is dropped
    do_reset();
    step();
    rst_n = 1'b1;
    run_to(19);
    sw = 1'b1;
    step();
    sw = 1'b0;
    run_to(26);
    chk("ign_dom_e26", 32'(dom), 32'b111);
    chk("ign_cause", 32'(cause), 32'd0);

    // asynchronous reset between edges 21 and 22
    do_reset();
    step();
    rst_n = 1'b1;
    run_to(21);
    #3;
    do_reset();
    repeat (3) step();
    rst_n = 1'b1;
    run_to(25);
    chk("async_dom_e25", 32'(dom), 32'b011);
    run_to(26);
    chk("async_done_e26", 32'(done), 32'd1);

`ifdef RST_SEQ_WDOG_EN
    // regular kicks keep the watchdog quiet
    run_to(27);
    for (int i = 0; i < 100; i++) begin
      alive = (i % 5 == 0);
      step();
    end
    alive = 1'b0;
    chk("kick_done", 32'(done), 32'd1);
    chk("kick_cause", 32'(cause), 32'd0);
`endif

    // random requests, kicks and asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      sw = ($urandom_range(0, 39) == 0);
      alive = ($urandom_range(0, 5) == 0);
      if (rst_n && $urandom_range(0, 299) == 0) begin
        #($urandom_range(1, 7));
        do_reset();
      end else if (!rst_n && $urandom_range(0, 3) == 0) begin
        rst_n = 1'b1;
      end
      step();
    end
    sw = 1'b0;
    alive = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
